// File: rtl/seq_tx_110.sv
// seq_tx_110 -- framed serial transmitter.
// A word offered on data_in/valid_in is sent on x_out as one bit per clock,
// optionally prefixed by the sync header 110, and followed by one GAP cycle
// that carries the frame_done pulse.
// Optional feature macro: SEQ_TX_110_SYNC_HDR_EN (header 110 compiled in).
// When the macro is undefined, frames carry the payload and the GAP cycle only.

module seq_tx_110 #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             x_out,
    output logic             busy,
    output logic             frame_done
);

    // Counter is wide enough to hold WIDTH, so the last data index never wraps.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
`ifdef SEQ_TX_110_SYNC_HDR_EN
    localparam logic [CW-1:0] LAST_HDR = CW'(2);
`endif

`ifdef SEQ_TX_110_SYNC_HDR_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             x_q, x_d;
    logic [WIDTH-1:0] shifted;

    // Next payload word position: the bit just sent leaves, the next one moves to the output end.
    always_comb begin
        shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
    end

    // Next-state logic; x_d is the bit that the following cycle will present, derived from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        x_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    shift_d = data_in;
                    cnt_d   = '0;
`ifdef SEQ_TX_110_SYNC_HDR_EN
                    state_d = HDR;
`else
                    state_d = DATA;
`endif
                end
            end
`ifdef SEQ_TX_110_SYNC_HDR_EN
            HDR: begin
                if (cnt_q == LAST_HDR) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            DATA: begin
                shift_d = shifted;
                if (cnt_q == LAST_BIT) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
`ifdef SEQ_TX_110_SYNC_HDR_EN
            HDR:     x_d = (cnt_d != LAST_HDR);
`endif
            DATA:    x_d = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
            default: x_d = 1'b0;
        endcase
    end

    // State, counter, shift register and the registered serial output; reset aborts any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            x_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            x_q     <= x_d;
        end
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        ready_out  = (state_q == IDLE);
        busy       = (state_q != IDLE);
        frame_done = (state_q == GAP);
        x_out      = x_q;
    end

endmodule

// File: tb/tb_seq_tx_110.sv
// Testbench for seq_tx_110: two instances (MSB-first and LSB-first) share the
// same stimulus; a scoreboard queue per instance holds the expected frame bits.
// Header expectations follow SEQ_TX_110_SYNC_HDR_EN exactly as the RTL does.

module tb_seq_tx_110;

`ifdef SEQ_TX_110_SYNC_HDR_EN
    localparam int HDR_LEN = 3;
`else
    localparam int HDR_LEN = 0;
`endif
    localparam int FRAME_LEN = HDR_LEN + 8 + 1;

    logic       clk;
    logic       rst;
    logic [7:0] dataIn;
    logic       validIn;
    logic       readyMsb, xMsb, busyMsb, doneMsb;
    logic       readyLsb, xLsb, busyLsb, doneLsb;

    int errorCount = 0;
    int checkCount = 0;
    int framesSent = 0;
    int cycleCount = 0;
    int doneCount  = 0;
    int acceptCycles[$];
    logic [1:0] expQMsb[$];
    logic [1:0] expQLsb[$];
    logic [1:0] detState = 2'd0;
    logic       detHit;

    seq_tx_110 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (dataIn),
        .valid_in  (validIn),
        .ready_out (readyMsb),
        .x_out     (xMsb),
        .busy      (busyMsb),
        .frame_done(doneMsb)
    );

    seq_tx_110 #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
        .clk       (clk),
        .rst       (rst),
        .data_in   (dataIn),
        .valid_in  (validIn),
        .ready_out (readyLsb),
        .x_out     (xLsb),
        .busy      (busyLsb),
        .frame_done(doneLsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter, accept-edge log, frame_done counter and a 110 Moore detector on the MSB stream.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
        if (rst && validIn && readyMsb) acceptCycles.push_back(cycleCount);
        if (doneMsb) doneCount <= doneCount + 1;
        case (detState)
            2'd0:    detState <= xMsb ? 2'd1 : 2'd0;
            2'd1:    detState <= xMsb ? 2'd2 : 2'd0;
            2'd2:    detState <= xMsb ? 2'd2 : 2'd3;
            default: detState <= xMsb ? 2'd1 : 2'd0;
        endcase
    end
    assign detHit = (detState == 2'd3);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] comparison %s did not hold", tag);
        end
    endtask

    // Expected {x_out, frame_done} for every cycle of one frame, for both bit orders.
    function automatic void pushFrame(input logic [7:0] word);
        if (HDR_LEN == 3) begin
            expQMsb.push_back(2'b10); expQMsb.push_back(2'b10); expQMsb.push_back(2'b00);
            expQLsb.push_back(2'b10); expQLsb.push_back(2'b10); expQLsb.push_back(2'b00);
        end
        for (int i = 0; i < 8; i++) begin
            expQMsb.push_back({word[7-i], 1'b0});
            expQLsb.push_back({word[i], 1'b0});
        end
        expQMsb.push_back(2'b01);
        expQLsb.push_back(2'b01);
    endfunction

    // Offer one word, then walk the whole frame and the trailing IDLE cycle against the scoreboard.
    task automatic applyStimulus(input logic [7:0] word, input bit keepValid,
                                 input logic [7:0] dataAfter, input bit toggle);
        logic [1:0] expMsb, expLsb;
        validIn = 1'b1;
        dataIn  = word;
        checkOutput("readyBeforeAccept", 32'(readyMsb), 32'd1);
        @(posedge clk);
        pushFrame(word);
        for (int k = 1; k <= FRAME_LEN; k++) begin
            @(negedge clk);
            expMsb = (expQMsb.size() != 0) ? expQMsb.pop_front() : 2'bxx;
            expLsb = (expQLsb.size() != 0) ? expQLsb.pop_front() : 2'bxx;
            checkOutput("xMsb", 32'(xMsb), 32'(expMsb[1]));
            checkOutput("doneMsb", 32'(doneMsb), 32'(expMsb[0]));
            checkOutput("xLsb", 32'(xLsb), 32'(expLsb[1]));
            checkOutput("doneLsb", 32'(doneLsb), 32'(expLsb[0]));
            checkOutput("busyInFrame", 32'(busyMsb), 32'd1);
            checkOutput("readyInFrame", 32'(readyMsb), 32'd0);
`ifdef SEQ_TX_110_SYNC_HDR_EN
            if (k == HDR_LEN + 1) checkOutput("hdrDetectHit", 32'(detHit), 32'd1);
`endif
            validIn = keepValid;
            dataIn  = toggle ? ~dataIn : dataAfter;
        end
        @(negedge clk);
        checkOutput("idleReady", 32'(readyMsb), 32'd1);
        checkOutput("idleBusy", 32'(busyLsb), 32'd0);
        checkOutput("idleX", 32'(xMsb), 32'd0);
        checkOutput("idleDone", 32'(doneMsb), 32'd0);
        framesSent++;
    endtask

    initial begin
        int n;
        int diff;
        int doneBefore;
        rst     = 1'b0;
        validIn = 1'b0;
        dataIn  = 8'h00;

        // Reset values while rst is held low.
        repeat (2) @(negedge clk);
        checkOutput("rstReady", 32'(readyMsb), 32'd1);
        checkOutput("rstBusy", 32'(busyMsb), 32'd0);
        checkOutput("rstX", 32'(xMsb), 32'd0);
        checkOutput("rstDone", 32'(doneMsb), 32'd0);
        checkOutput("rstXLsb", 32'(xLsb), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Reference words in both bit orders.
        applyStimulus(8'hA5, 1'b0, 8'h00, 1'b0);
        applyStimulus(8'h01, 1'b0, 8'h00, 1'b0);

        // valid_in held high: FF then 00 back to back, spacing is frame length plus one.
        applyStimulus(8'hFF, 1'b1, 8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
        n = acceptCycles.size();
        checkOutput("acceptLogSize", 32'(n), 32'(framesSent));
        diff = (n >= 2) ? acceptCycles[n-1] - acceptCycles[n-2] : 0;
        checkOutput("acceptSpacing", 32'(diff), 32'(FRAME_LEN + 1));

        // Abort during DATA bit 4.
        validIn = 1'b1;
        dataIn  = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        validIn = 1'b0;
        repeat (HDR_LEN + 3) @(negedge clk);
        checkOutput("busyBeforeAbort", 32'(busyMsb), 32'd1);
        doneBefore = doneCount;
        rst = 1'b0;
        #1;
        checkOutput("abortX", 32'(xMsb), 32'd0);
        checkOutput("abortBusy", 32'(busyMsb), 32'd0);
        checkOutput("abortReady", 32'(readyMsb), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("abortNoDone", 32'(doneCount), 32'(doneBefore));
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(8'h5A, 1'b0, 8'h00, 1'b0);

        // data_in toggling after accept must not disturb the payload.
        applyStimulus(8'h3C, 1'b0, 8'h00, 1'b1);

        // Random words back to back.
        for (int i = 0; i < 1000; i++)
            applyStimulus(8'($urandom_range(0, 255)), 1'b0, 8'($urandom_range(0, 255)), 1'b0);

        checkOutput("frameDoneTotal", 32'(doneCount), 32'(framesSent));
        checkOutput("acceptTotal", 32'(acceptCycles.size()), 32'(framesSent + 1));
        checkOutput("scoreboardEmpty", 32'(expQMsb.size() + expQLsb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/seq_tx_110.md
SEQ_TX_110 -- requirements
Module: seq_tx_110

Interface
REQ-001 Parameter WIDTH, 8, payload bits per frame; legal range 2..32.
REQ-002 Parameter MSB_FIRST, 1, payload bit order: 1 = MSB first, 0 = LSB first.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 data_in  input  WIDTH  payload word offered for transmission.
REQ-006 valid_in  input  1  data_in valid.
REQ-007 ready_out  output  1  block can accept a word this cycle.
REQ-008 x_out  output  1  registered serial bit stream, one bit per clk.
REQ-009 busy  output  1  a frame is being transmitted.
REQ-010 frame_done  output  1  single-cycle pulse marking the last cycle of a frame.

Function
REQ-011 FSM states SHALL be IDLE, HDR, DATA and GAP.
REQ-012 ready_out SHALL equal (state == IDLE).
REQ-013 busy SHALL equal (state != IDLE).
REQ-014 A word SHALL be accepted on the rising edge where valid_in && ready_out; data_in SHALL be captured into an internal shift register at that edge.
REQ-015 valid_in SHALL be ignored outside IDLE; words are neither queued nor dropped silently, because ready_out is low.
REQ-016 Accept edge: the next state SHALL be HDR when SYNC_HDR_EN is defined, otherwise DATA.
REQ-017 HDR SHALL last exactly 3 cycles and drive x_out = 1, 1, 0 in that order; then go to DATA.
REQ-018 DATA SHALL last exactly WIDTH cycles and drive one payload bit per cycle in MSB_FIRST order; then go to GAP.
REQ-019 GAP SHALL last exactly 1 cycle with x_out = 0 and frame_done = 1; then go to IDLE.
REQ-020 In IDLE, x_out SHALL be 0 and frame_done SHALL be 0.
REQ-021 x_out SHALL change only on a rising clk edge; the first frame bit SHALL appear in the cycle after the accept edge.
REQ-022 Frame length SHALL be 3+WIDTH+1 cycles with the header, WIDTH+1 without.
REQ-023 Minimum accept-to-accept spacing SHALL be the frame length plus 1 IDLE cycle.
REQ-024 A bit counter SHALL be sized ceil(log2(WIDTH+1)) bits and SHALL never wrap within a frame.
REQ-025 data_in changes after the accept edge SHALL NOT affect the frame in flight.

Reset
REQ-026 While rst is low: state = IDLE, x_out = 0, frame_done = 0, busy = 0, ready_out = 1, shift register and counter = 0.
REQ-027 Assertion of rst mid-frame SHALL abort the frame immediately, with no frame_done pulse.
REQ-028 After rst deasserts, the first accept edge SHALL start a complete new frame.

Configuration
REQ-029 Macro SEQ_TX_110_SYNC_HDR_EN is defined: HDR state is compiled in and every frame is prefixed with header 110.
REQ-030 Macro SEQ_TX_110_SYNC_HDR_EN is undefined: HDR state and its logic are absent, and frames consist of payload plus GAP only.

Verification
REQ-031 Header on, WIDTH=8, MSB_FIRST=1; accept 8'hA5 -> x_out = 1,1,0,1,0,1,0,0,1,0,1,0 over 12 cycles; frame_done high in cycle 12 only; ready_out low for cycles 1-12.
REQ-032 MSB_FIRST=0, header off; accept 8'h01 -> x_out = 1,0,0,0,0,0,0,0,0 over 9 cycles; frame_done in cycle 9.
REQ-033 valid_in held high with 8'hFF then 8'h00 -> second accept occurs exactly 13 cycles after the first (header on); both frames are bit-exact.
REQ-034 rst pulled low during DATA bit 4 -> x_out = 0, busy = 0 immediately; no frame_done pulse; the next accept yields a full frame.
REQ-035 data_in toggled every cycle after the accept of 8'h3C -> transmitted payload remains 0,0,1,1,1,1,0,0.
REQ-036 Loopback x_out into a 110 Moore detector, random words x 1000 (header on) -> a detector hit at every header, and no frame lost or duplicated.
